// File: rtl/student_fir_scheduler.sv
// student_fir_scheduler: sequences a daisy-chained bank of student_fir cores.
// One strobe per accepted sample, gathers every core's done pulse, adds the
// partial results one core per cycle, then scales and saturates the sum.
// Optional feature macro: STUDENT_FIR_SCHED_OVERRUN_CNT_EN enables the
// dropped-sample counter; without it overrun_cnt_o is tied to zero.
module student_fir_scheduler #(
  parameter int NUM_FIR           = 4,
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int DATA_SIZE_OUT     = 24,
  parameter int OUT_SHIFT         = 8,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   sample_valid_i,
  input  logic [DATA_SIZE-1:0]                   sample_i,
  output logic                                   fir_strobe_o,
  output logic [DATA_SIZE-1:0]                   fir_sample_o,
  input  logic [NUM_FIR-1:0]                     fir_done_i,
  input  logic [NUM_FIR*DATA_SIZE_FIR_OUT-1:0]   fir_y_i,
  output logic                                   y_valid_o,
  output logic [DATA_SIZE_OUT-1:0]               y_o,
  output logic                                   busy_o,
  output logic                                   timeout_o,
  input  logic                                   clear_i,
  output logic [15:0]                            overrun_cnt_o
);

  // Accumulator carries enough headroom that summing every core never wraps.
  localparam int ACC_W = DATA_SIZE_FIR_OUT + $clog2(NUM_FIR) + 1;
  localparam int IDX_W = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT,
    ST_SUM,
    ST_OUT
  } state_t;

  state_t                               state_q, state_d;
  logic [DATA_SIZE-1:0]                 sample_q, sample_d;
  logic [NUM_FIR-1:0]                   mask_q, mask_d;
  logic [NUM_FIR*DATA_SIZE_FIR_OUT-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [ACC_W-1:0]                     acc_q, acc_d;
  logic [WD_W-1:0]                      wd_q, wd_d;
  logic [DATA_SIZE_OUT-1:0]             y_q, y_d;
  logic                                 timeout_q, timeout_d;
  logic                                 timeout_set;
  logic [NUM_FIR-1:0]                   mask_all;

  // Shift the unsigned sum down, then clamp anything wider than the output.
  function automatic logic [DATA_SIZE_OUT-1:0] sat_scale(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    r = acc >> OUT_SHIFT;
    if ((r >> DATA_SIZE_OUT) != '0) sat_scale = '1;
    else                            sat_scale = r[DATA_SIZE_OUT-1:0];
  endfunction

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    mask_d      = mask_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    wd_d        = wd_q;
    y_d         = y_q;
    timeout_set = 1'b0;
    mask_all    = mask_q | fir_done_i;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid_i) begin
          sample_d = sample_i;
          mask_d   = '0;
          wd_d     = '0;
          state_d  = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // A done pulse coinciding with the strobe cycle must not be lost.
        mask_d  = mask_all;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mask_d = mask_all;
        if (&mask_all) begin
          snap_d  = fir_y_i;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_SUM;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
            timeout_set = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_SUM: begin
        acc_d = acc_q + ACC_W'(snap_q[int'(idx_q)*DATA_SIZE_FIR_OUT +: DATA_SIZE_FIR_OUT]);
        if (idx_q == IDX_W'(NUM_FIR - 1)) begin
          y_d     = sat_scale(acc_d);
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    timeout_d = clear_i ? 1'b0 : (timeout_q | timeout_set);
  end

  // State and datapath registers; reset discards any in-flight work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      sample_q  <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      wd_q      <= '0;
      y_q       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      wd_q      <= wd_d;
      y_q       <= y_d;
      timeout_q <= timeout_d;
    end
  end

  // Snapshot of the core outputs is only read after being loaded, so no reset.
  always_ff @(posedge clk_i) begin
    snap_q <= snap_d;
  end

`ifdef STUDENT_FIR_SCHED_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;
  logic        drop;

  // Count samples refused while busy; clear wins, count saturates.
  always_comb begin
    drop  = sample_valid_i && (state_q != ST_IDLE);
    ovr_d = ovr_q;
    if (clear_i)                          ovr_d = '0;
    else if (drop && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
  end

  // Overrun counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovr_q <= '0;
    else         ovr_q <= ovr_d;
  end

  assign overrun_cnt_o = ovr_q;
`else
  assign overrun_cnt_o = '0;
`endif

  assign fir_strobe_o = (state_q == ST_STROBE);
  assign fir_sample_o = sample_q;
  assign y_valid_o    = (state_q == ST_OUT);
  assign y_o          = y_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign timeout_o    = timeout_q;

endmodule
